gcd_core: RTL
=============

GCD_CORE -- requirements
Module: gcd_core

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits (>=2).
REQ-002 Parameter: CNT_W, 16, iteration-counter width in bits (>=1).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to load new operands; accepted only when in_ready=1.
REQ-006 clear  input  1  synchronous abort; returns block to IDLE.
REQ-007 data1  input  WIDTH  operand A, unsigned.
REQ-008 data2  input  WIDTH  operand B, unsigned.
REQ-009 in_ready  output  1  high exactly when state is IDLE.
REQ-010 busy  output  1  high exactly when state is CALC.
REQ-011 out_valid  output  1  high exactly when state is DONE.
REQ-012 out_ready  input  1  consumer accepts result while out_valid=1.
REQ-013 result  output  WIDTH  gcd(data1,data2), registered; stable while out_valid=1.
REQ-014 iter_cnt  output  CNT_W  number of subtraction steps taken, registered; stable while out_valid=1.
REQ-015 lt, gt, eq  output  1 each  registered unsigned compare of working regs A vs B (A<B, A>B, A==B).

Function
REQ-016 States SHALL be IDLE, CALC, DONE; encoding is implementation choice.
REQ-017 IDLE: start=1 and clear=0 at an edge SHALL load A<=data1, B<=data2, iter_cnt<=0, go to CALC (edge E0).
REQ-018 CALC, each edge: if A==0 or B==0, result<=A|B, go DONE; else if A==B, result<=A, go DONE; else if A>B, A<=A-B; else B<=B-A.
REQ-019 Each subtraction step SHALL increment iter_cnt by 1, saturating at 2^CNT_W-1; transition edges do not increment.
REQ-020 Latency: out_valid SHALL rise after edge E0+1+iter_cnt (final iter_cnt value); gcd(0,0) SHALL give result 0.
REQ-021 lt/gt/eq SHALL reflect A/B as held after each edge; exactly one is high at any time.
REQ-022 DONE: out_valid=1 with out_ready=1 at an edge SHALL return to IDLE; without out_ready, DONE and result/iter_cnt SHALL hold indefinitely.
REQ-023 start while not IDLE SHALL be ignored with no effect on A, B, result, iter_cnt.
REQ-024 clear=1 at an edge in any state SHALL force IDLE; result and iter_cnt SHALL hold last values; clear has priority over start and out_ready.
REQ-025 Subtraction is WIDTH-bit unsigned; per REQ-018 the larger operand is always the minuend, so no underflow occurs.
REQ-026 All outputs SHALL be driven from registers or state decode only; no combinational path from inputs to outputs.

Reset
REQ-027 rst_n=0 SHALL immediately (asynchronously) force state IDLE, A=B=0, result=0, iter_cnt=0, lt=0, gt=0, eq=1, so in_ready=1, busy=0, out_valid=0.
REQ-028 Reset asserted mid-CALC or in DONE SHALL discard the operation; first edge after release with start=1 SHALL load normally.

Verification
REQ-029 data1=12, data2=8, start 1 cycle, out_ready=1 -> busy 3 cycles, out_valid 1 cycle, result=4, iter_cnt=2.
REQ-030 data1=25, data2=25 -> out_valid after E0+1, result=25, iter_cnt=0, eq=1 at load.
REQ-031 data1=0, data2=9, then data1=0, data2=0 -> result=9 then 0, iter_cnt=0 each.
REQ-032 WIDTH=16, data1=16'hFFFF, data2=1, out_ready=0 for 10 cycles after out_valid -> result=1, iter_cnt=65534, outputs held until out_ready=1.
REQ-033 data1=100, data2=75, start pulsed again during CALC, clear at 2nd CALC edge -> second start ignored; IDLE after clear, result/iter_cnt unchanged.
REQ-034 rst_n low between edges during CALC -> outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/gcd_core.sv
// Subtractive GCD engine: loads two unsigned operands, repeatedly subtracts the
// smaller from the larger, and reports the result plus the number of steps taken.
module gcd_core #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             clear,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   output logic             in_ready,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [CNT_W-1:0] iter_cnt,
   output logic             lt,
   output logic             gt,
   output logic             eq
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a, b;
   logic [WIDTH-1:0] a_nxt, b_nxt;
   logic [WIDTH-1:0] result_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] cnt_inc;

   assign cnt_inc = (iter_cnt == CNT_MAX) ? iter_cnt : iter_cnt + CNT_ONE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      a_nxt      = a;
      b_nxt      = b;
      result_nxt = result;
      cnt_nxt    = iter_cnt;
      if (clear) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_nxt     = data1;
                  b_nxt     = data2;
                  cnt_nxt   = '0;
                  state_nxt = CALC;
               end
            end
            CALC: begin
               if (a == '0 || b == '0) begin
                  result_nxt = a | b;
                  state_nxt  = DONE;
               end else if (a == b) begin
                  result_nxt = a;
                  state_nxt  = DONE;
               end else if (a > b) begin
                  a_nxt   = a - b;
                  cnt_nxt = cnt_inc;
               end else begin
                  b_nxt   = b - a;
                  cnt_nxt = cnt_inc;
               end
            end
            DONE: begin
               if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Flags are registered from the next-state operands so they always match A/B as held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a        <= '0;
         b        <= '0;
         result   <= '0;
         iter_cnt <= '0;
         lt       <= 1'b0;
         gt       <= 1'b0;
         eq       <= 1'b1;
      end else begin
         a        <= a_nxt;
         b        <= b_nxt;
         result   <= result_nxt;
         iter_cnt <= cnt_nxt;
         lt       <= (a_nxt < b_nxt);
         gt       <= (a_nxt > b_nxt);
         eq       <= (a_nxt == b_nxt);
      end
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state == CALC);
   assign out_valid = (state == DONE);

endmodule
